// File: rtl/div_pkg.sv
// Shared definitions for the multicycle RV32M divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: magnitude division, one
// quotient bit per cycle, then a single sign fix-up cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic             sel_rem_q, sel_rem_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             accept;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             ge;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      sel_rem_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    res_d     = res_q;

    signed_op = (div_op == DIV_OP_DIV) || (div_op == DIV_OP_REM);
    sa        = signed_op & op_a[WIDTH-1];
    sb        = signed_op & op_b[WIDTH-1];
    mag_a     = sa ? (~op_a + WIDTH'(1)) : op_a;
    mag_b     = sb ? (~op_b + WIDTH'(1)) : op_b;
    accept    = start && !abort && (state_q == IDLE || state_q == DONE);

    // 33-bit step: remainder can exceed 2^(WIDTH-1) for large unsigned divisors
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    ge        = ~rem_sub[WIDTH];

    quo_fix   = (sign_a_q ^ sign_b_q) ? (~quo_q + WIDTH'(1)) : quo_q;
    rem_fix   = sign_a_q ? (~rem_q + WIDTH'(1)) : rem_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          sel_rem_d = div_op[1];
          sign_a_d  = sa;
          sign_b_d  = sb;
          quo_d     = mag_a;
          dvs_d     = mag_b;
          rem_d     = '0;
          cnt_d     = CNT_W'(WIDTH - 1);
          if (op_b == '0) begin
            res_d   = div_op[1] ? op_a : '1;
            state_d = DONE;
          end else if (signed_op && op_a == MIN_NEG && op_b == '1) begin
            res_d   = div_op[1] ? '0 : MIN_NEG;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = SIGN;
      end
      SIGN: begin
        res_d   = sel_rem_q ? rem_fix : quo_fix;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including a same-cycle start
    if (abort) state_d = IDLE;

    busy_d = (state_d == CALC) || (state_d == SIGN);
    done_d = (state_d == DONE);
  end

  assign res  = res_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector and reference-model bench for div_unit.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic        abort;
  logic [1:0]  div_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] res;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  div_unit dut (
    .clk    (clk),
    .nrst   (nrst),
    .start  (start),
    .abort  (abort),
    .div_op (div_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .res    (res),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_op = op;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    div_op = 2'($urandom_range(0, 3));
  endtask

  // lat counts negedges since the start cycle; bounded so a lost done cannot hang
  task automatic wait_done(input int first, output int lat, output int bcnt);
    lat  = first;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0)
      r = op[1] ? a : 32'hFFFF_FFFF;
    else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      r = op[1] ? 32'd0 : 32'h8000_0000;
    else begin
      case (op)
        DIV_OP_DIV:  r = 32'($signed(a) / $signed(b));
        DIV_OP_DIVU: r = a / b;
        DIV_OP_REM:  r = 32'($signed(a) % $signed(b));
        default:     r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LATENCY;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  vec_t vecs[$];
  int   lat;
  int   bcnt;

  initial begin
    vecs.push_back('{DIV_OP_DIV,  32'd100,         32'd7,           32'd14,          34});
    vecs.push_back('{DIV_OP_REM,  32'd100,         32'd7,           32'd2,           34});
    vecs.push_back('{DIV_OP_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   34});
    vecs.push_back('{DIV_OP_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   34});
    vecs.push_back('{DIV_OP_REM,  32'd7,           32'hFFFF_FFFE,   32'd1,           34});
    vecs.push_back('{DIV_OP_DIVU, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   34});
    vecs.push_back('{DIV_OP_DIV,  32'd5,           32'd0,           32'hFFFF_FFFF,   1});
    vecs.push_back('{DIV_OP_REMU, 32'd5,           32'd0,           32'd5,           1});
    vecs.push_back('{DIV_OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1});
    vecs.push_back('{DIV_OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1});
    vecs.push_back('{DIV_OP_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           34});
    vecs.push_back('{DIV_OP_REMU, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   34});
    vecs.push_back('{DIV_OP_DIVU, 32'hFFFF_FFFF,   32'hFFFF_FFFE,   32'd1,           34});
    vecs.push_back('{DIV_OP_REMU, 32'hFFFF_FFFF,   32'hFFFF_FFFE,   32'd1,           34});
    vecs.push_back('{DIV_OP_DIV,  32'hFFFF_FF9C,   32'hFFFF_FFF9,   32'd14,          34});
    vecs.push_back('{DIV_OP_REM,  32'hFFFF_FF9C,   32'hFFFF_FFF9,   32'hFFFF_FFFE,   34});
    vecs.push_back('{DIV_OP_DIV,  32'h8000_0000,   32'd2,           32'hC000_0000,   34});
    vecs.push_back('{DIV_OP_DIVU, 32'd0,           32'd3,           32'd0,           34});

    nrst = 1'b0; start = 1'b0; abort = 1'b0;
    div_op = DIV_OP_DIV; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("reset_res", res, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back from the DONE cycle
    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, lat, bcnt);
      check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].exp_lat - 1));
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // Abort on the 10th CALC cycle: no done, res untouched
    start_op(DIV_OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_res_hold", res, 32'd0);
    wait_done(0, lat, bcnt);
    check("abort_no_done", 32'(lat >= 200), 32'd1);
    start_op(DIV_OP_DIVU, 32'd9, 32'd3);
    wait_done(1, lat, bcnt);
    check("post_abort_res", res, 32'd3);
    check("post_abort_lat", 32'(lat), 32'd34);

    // start together with abort while idle: nothing accepted
    @(negedge clk);
    abort = 1'b1;
    start_op(DIV_OP_DIV, 32'd50, 32'd5);
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_done", 32'(done), 32'd0);

    // start while busy is ignored
    start_op(DIV_OP_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start_op(DIV_OP_REM, 32'd1, 32'd0);
    wait_done(5, lat, bcnt);
    check("busy_start_res", res, 32'd14);
    check("busy_start_lat", 32'(lat), 32'd34);

    // Reset mid-CALC clears outputs and produces no done
    @(negedge clk);
    start_op(DIV_OP_DIV, 32'd77, 32'd5);
    repeat (9) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("rst_mid_res", res, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    nrst = 1'b1;
    wait_done(0, lat, bcnt);
    check("rst_mid_no_done", 32'(lat >= 200), 32'd1);

    // Reference-model run, each op started in the previous DONE cycle
    for (int k = 0; k < 1200; k++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      start_op(rop, ra, rb);
      wait_done(1, lat, bcnt);
      check($sformatf("rnd%0d_res op=%0d a=%h b=%h", k, rop, ra, rb), res, ref_div(rop, ra, rb));
      check($sformatf("rnd%0d_lat", k), 32'(lat), 32'(ref_lat(rop, ra, rb)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
